// File: rtl/controle_display_jogo_pkg.sv
// Shared definitions for the tic-tac-toe status display: segment codes,
// state encoding and the player-to-digit mapping.
package pkg_display_jogo;

  // Active-low segment patterns, bit order g..a (bit0 = a)
  localparam logic [6:0] SEG_J       = 7'b1100001;
  localparam logic [6:0] SEG_E       = 7'b0000110;
  localparam logic [6:0] SEG_1       = 7'b1111001;
  localparam logic [6:0] SEG_2       = 7'b0100100;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    VEZ     = 3'd1,
    ERRO    = 3'd2,
    VITORIA = 3'd3,
    EMPATE  = 3'd4
  } estado_t;

  // Player bit 0 shows "1", player bit 1 shows "2"
  function automatic logic [6:0] digito_jogador(input logic jog);
    return jog ? SEG_2 : SEG_1;
  endfunction

endpackage

// File: rtl/controle_display_jogo_gerador_pisca.sv
// Blink phase generator: phase toggles every PERIODO enabled cycles and
// restarts at the visible phase whenever limpar_i is asserted.
// fase_prox_o is the phase that will be held during the next cycle, so a
// registered display can be driven from it without an extra cycle of skew.
module gerador_pisca
  import pkg_display_jogo::*;
#(
  parameter int PERIODO = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic limpar_i,
  input  logic habilitar_i,
  output logic fase_prox_o
);

  localparam int CW = $clog2(PERIODO);

  logic [CW-1:0] cont_q, cont_d;
  logic          fase_q, fase_d;

  // Next counter/phase: clear wins, otherwise count while enabled
  always_comb begin
    cont_d = cont_q;
    fase_d = fase_q;
    if (limpar_i) begin
      cont_d = '0;
      fase_d = 1'b0;
    end else if (habilitar_i) begin
      if (cont_q == CW'(PERIODO - 1)) begin
        cont_d = '0;
        fase_d = ~fase_q;
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  // Counter and phase registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_q <= '0;
      fase_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      fase_q <= fase_d;
    end
  end

  assign fase_prox_o = fase_d;

endmodule

// File: rtl/controle_display_jogo.sv
// Status display sequencer for the tic-tac-toe game (HEX1 = letter,
// HEX0 = digit). Handles message priority, the error hold timer and,
// when CONTROLE_DISPLAY_PISCA_EN is defined, blinking of the error and
// winner messages. Display outputs are registered from the next state.
module controle_display_jogo
  import pkg_display_jogo::*;
#(
  parameter int HOLD_ERRO     = 100,
  parameter int PISCA_PERIODO = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogador,
  input  logic       jogada_invalida,
  input  logic       vitoria,
  input  logic       empate,
  output logic [6:0] hex_letra,
  output logic [6:0] hex_numero,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  localparam int HW = $clog2(HOLD_ERRO);

  estado_t       estado_q, estado_d;
  logic [HW-1:0] cont_q, cont_d;
  logic          vencedor_q, vencedor_d;
  logic [6:0]    letra_q, letra_d;
  logic [6:0]    numero_q, numero_d;
  logic          ocupado_q, ocupado_d;
  logic          reentrada;

  // Next state, hold counter and winner latch
  always_comb begin
    estado_d   = estado_q;
    cont_d     = '0;
    vencedor_d = vencedor_q;
    reentrada  = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = VEZ;
      end
      VEZ, ERRO: begin
        if (iniciar) begin
          estado_d = VEZ;
        end else if (vitoria) begin
          estado_d   = VITORIA;
          vencedor_d = jogador;
        end else if (empate) begin
          estado_d = EMPATE;
        end else if (jogada_invalida) begin
          // A repeated error restarts the hold (and blink) timing
          estado_d  = ERRO;
          reentrada = 1'b1;
        end else if (estado_q == ERRO) begin
          if (cont_q == HW'(HOLD_ERRO - 1)) estado_d = VEZ;
          else                              cont_d   = cont_q + 1'b1;
        end
      end
      VITORIA, EMPATE: begin
        if (iniciar) estado_d = VEZ;
      end
      default: estado_d = INICIAL;
    endcase
  end

`ifdef CONTROLE_DISPLAY_PISCA_EN
  logic estado_pisca_d;
  logic fase_prox;

  assign estado_pisca_d = (estado_d == ERRO) || (estado_d == VITORIA);

  gerador_pisca #(
    .PERIODO(PISCA_PERIODO)
  ) u_pisca (
    .clock       (clock),
    .reset       (reset),
    .limpar_i    (estado_pisca_d && ((estado_d != estado_q) || reentrada)),
    .habilitar_i ((estado_q == ERRO) || (estado_q == VITORIA)),
    .fase_prox_o (fase_prox)
  );
`endif

  // Display contents for the state being entered
  always_comb begin
    letra_d   = SEG_TRACO;
    numero_d  = SEG_TRACO;
    ocupado_d = (estado_d == ERRO);
    unique case (estado_d)
      INICIAL: begin
        letra_d  = SEG_TRACO;
        numero_d = SEG_TRACO;
      end
      VEZ: begin
        letra_d  = SEG_J;
        numero_d = digito_jogador(jogador);
      end
      ERRO: begin
        letra_d  = SEG_E;
        numero_d = digito_jogador(jogador);
      end
      VITORIA: begin
        letra_d  = SEG_J;
        numero_d = digito_jogador(vencedor_d);
      end
      EMPATE: begin
        letra_d  = SEG_E;
        numero_d = SEG_APAGADO;
      end
      default: begin
        letra_d  = SEG_TRACO;
        numero_d = SEG_TRACO;
      end
    endcase
`ifdef CONTROLE_DISPLAY_PISCA_EN
    if (estado_pisca_d && fase_prox) begin
      letra_d  = SEG_APAGADO;
      numero_d = SEG_APAGADO;
    end
`endif
  end

  // State, counter and winner registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      cont_q     <= '0;
      vencedor_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      vencedor_q <= vencedor_d;
    end
  end

  // Registered display outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      letra_q   <= SEG_TRACO;
      numero_q  <= SEG_TRACO;
      ocupado_q <= 1'b0;
    end else begin
      letra_q   <= letra_d;
      numero_q  <= numero_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign hex_letra  = letra_q;
  assign hex_numero = numero_q;
  assign ocupado    = ocupado_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_controle_display_jogo.sv
// Self-checking bench for controle_display_jogo (default parameters).
module tb_controle_display_jogo;

  localparam logic [6:0] J  = 7'b1100001;
  localparam logic [6:0] E  = 7'b0000110;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] TR = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef CONTROLE_DISPLAY_PISCA_EN
  localparam bit PISCA = 1'b1;
`else
  localparam bit PISCA = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogador, jogada_invalida, vitoria, empate;
  logic [6:0] hex_letra, hex_numero;
  logic       ocupado;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] l;
    logic [6:0] n;
    logic       oc;
  } exp_t;

  typedef struct packed {
    logic ini, jog, inv, vit, emp;
    exp_t e;
  } vec_t;

  exp_t  sb[$];
  vec_t  tab[23];

  controle_display_jogo dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogador         (jogador),
    .jogada_invalida (jogada_invalida),
    .vitoria         (vitoria),
    .empate          (empate),
    .hex_letra       (hex_letra),
    .hex_numero      (hex_numero),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, " estado"},  32'(db_estado),  32'(e.st));
    chk({nm, " letra"},   32'(hex_letra),  32'(e.l));
    chk({nm, " numero"},  32'(hex_numero), 32'(e.n));
    chk({nm, " ocupado"}, 32'(ocupado),    32'(e.oc));
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk_all(nm, e);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 time unit after the rising edge
  task automatic cycle(input logic ini, input logic jog, input logic inv,
                       input logic vit, input logic emp);
    @(negedge clock);
    iniciar = ini; jogador = jog; jogada_invalida = inv; vitoria = vit; empate = emp;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    bit vis;

    // state, letter, digit, busy expected after each row
    tab[0]  = '{0,0,0,1,0, '{3'd0, TR, TR, 1'b0}};  // INICIAL ignores vitoria
    tab[1]  = '{0,0,1,0,0, '{3'd0, TR, TR, 1'b0}};  // and jogada_invalida
    tab[2]  = '{1,0,0,0,0, '{3'd1, J,  D1, 1'b0}};
    tab[3]  = '{0,1,0,0,0, '{3'd1, J,  D2, 1'b0}};  // tracks jogador
    tab[4]  = '{0,0,0,0,0, '{3'd1, J,  D1, 1'b0}};
    tab[5]  = '{0,1,1,0,0, '{3'd2, E,  D2, 1'b1}};
    tab[6]  = '{0,0,0,0,0, '{3'd2, E,  D1, 1'b1}};
    tab[7]  = '{1,0,1,1,0, '{3'd1, J,  D1, 1'b0}};  // iniciar beats all
    tab[8]  = '{0,1,1,1,0, '{3'd3, J,  D2, 1'b0}};  // vitoria beats invalida
    tab[9]  = '{0,0,0,0,0, '{3'd3, J,  D2, 1'b0}};  // winner latched
    tab[10] = '{0,0,1,0,0, '{3'd3, J,  D2, 1'b0}};
    tab[11] = '{0,1,0,0,1, '{3'd3, J,  D2, 1'b0}};
    tab[12] = '{1,1,0,0,0, '{3'd1, J,  D2, 1'b0}};
    tab[13] = '{0,1,1,0,1, '{3'd4, E,  BL, 1'b0}};  // empate beats invalida
    tab[14] = '{0,0,1,0,0, '{3'd4, E,  BL, 1'b0}};
    tab[15] = '{0,0,0,1,0, '{3'd4, E,  BL, 1'b0}};
    tab[16] = '{1,0,0,1,0, '{3'd1, J,  D1, 1'b0}};  // iniciar beats vitoria
    tab[17] = '{0,0,1,0,0, '{3'd2, E,  D1, 1'b1}};
    tab[18] = '{0,0,1,0,1, '{3'd4, E,  BL, 1'b0}};  // empate from ERRO
    tab[19] = '{1,0,0,0,0, '{3'd1, J,  D1, 1'b0}};
    tab[20] = '{0,1,1,0,0, '{3'd2, E,  D2, 1'b1}};
    tab[21] = '{0,1,0,1,0, '{3'd3, J,  D2, 1'b0}};  // vitoria from ERRO
    tab[22] = '{1,0,0,0,0, '{3'd1, J,  D1, 1'b0}};

    reset = 1'b1;
    iniciar = 0; jogador = 0; jogada_invalida = 0; vitoria = 0; empate = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", '{3'd0, TR, TR, 1'b0});
    @(negedge clock);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 23; i++) begin
      sb.push_back(tab[i].e);
      cycle(tab[i].ini, tab[i].jog, tab[i].inv, tab[i].vit, tab[i].emp);
      sb_check($sformatf("vec%0d", i));
    end

    // Error hold: exactly 100 cycles, then back to VEZ
    cycle(0, 0, 1, 0, 0);
    chk_all("erro entrada", '{3'd2, E, D1, 1'b1});
    n = 1;
    for (int k = 0; k < 400; k++) begin
      cycle(0, 0, 0, 0, 0);
      if (db_estado == 3'd2 && ocupado) n++;
      else break;
    end
    chk("erro duracao", 32'(n), 32'd100);
    chk_all("erro saida", '{3'd1, J, D1, 1'b0});

    // Second error during the 50th ERRO cycle stretches it to 150
    cycle(0, 1, 1, 0, 0);
    n = 1;
    for (int k = 0; k < 49; k++) begin
      cycle(0, 1, 0, 0, 0);
      if (db_estado == 3'd2 && ocupado) n++;
    end
    cycle(0, 1, 1, 0, 0);
    if (db_estado == 3'd2 && ocupado) n++;
    for (int k = 0; k < 400; k++) begin
      cycle(0, 1, 0, 0, 0);
      if (db_estado == 3'd2 && ocupado) n++;
      else break;
    end
    chk("erro estendido", 32'(n), 32'd150);
    chk_all("erro estendido saida", '{3'd1, J, D2, 1'b0});

    // Winner message over 60 cycles while jogador keeps toggling
    for (int i = 1; i <= 60; i++) begin
      vis = !PISCA || (((i - 1) / 25) % 2 == 0);
      sb.push_back('{3'd3, vis ? J : BL, vis ? D2 : BL, 1'b0});
      if (i == 1) cycle(0, 1, 0, 1, 0);
      else        cycle(0, 1'(i % 2), 0, 0, 0);
      sb_check($sformatf("vitoria c%0d", i));
    end
    cycle(1, 0, 0, 0, 0);
    chk_all("vitoria iniciar", '{3'd1, J, D1, 1'b0});

    // Asynchronous reset in the middle of an error message
    cycle(0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    chk_all("pre reset", '{3'd2, E, D1, 1'b1});
    #2 reset = 1'b1;
    #1;
    chk_all("reset async", '{3'd0, TR, TR, 1'b0});
    @(negedge clock);
    reset = 1'b0;
    cycle(1, 0, 0, 0, 0);
    chk_all("pos reset iniciar", '{3'd1, J, D1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_display_jogo.md
Name: controle_display_jogo

Overview:
- Sequences the two-digit 7-segment status display of the tic-tac-toe game.
- Shows the current player, invalid-move errors, the winner and draws.
- Sits between the game FSM (event pulses, current player) and the HEX0/HEX1 pins.
- Owns the message priority, the error hold timer and the blink timing. Segment patterns are generated internally.

Parameters:
HOLD_ERRO, 100, cycles the error message is held before returning to the turn display (>=2)
PISCA_PERIODO, 25, cycles per blink half-period (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  one-cycle pulse; starts or restarts a game
jogador  in  1  current player: 0 = J1, 1 = J2
jogada_invalida  in  1  one-cycle pulse; the attempted move was rejected
vitoria  in  1  one-cycle pulse; the current jogador has won
empate  in  1  one-cycle pulse; the board is full with no winner
hex_letra  out  7  segments g..a, active-low (bit0 = a)
hex_numero  out  7  segments g..a, active-low
ocupado  out  1  1 while in ERRO (timed message active)
db_estado  out  3  state encoding, for debug

Behaviour:
- Segment codes (active-low): J=1100001, E=0000110, 1=1111001, 2=0100100, dash=0111111, blank=1111111.
- Reset (async, any time, including mid-message):
  - state INICIAL; both displays dash; ocupado=0.
  - counters and vencedor cleared.
- States (db_estado): INICIAL=0, VEZ=1, ERRO=2, VITORIA=3, EMPATE=4.
- Outputs are registered and update on the clock edge after the state/input that causes them (1-cycle latency).
- INICIAL: displays "--". iniciar -> VEZ. All other events are ignored.
- VEZ: displays "J" + digit(jogador+1), tracking jogador with 1-cycle latency.
- Event priority in VEZ and ERRO: iniciar > vitoria > empate > jogada_invalida.
  - iniciar -> VEZ, counters cleared.
  - vitoria -> VITORIA; vencedor latched from jogador in the same cycle.
  - empate -> EMPATE.
  - jogada_invalida -> ERRO; hold counter cleared.
- ERRO:
  - Display is "E" + digit(jogador+1); ocupado=1.
  - Hold counter increments each cycle. Exits to VEZ on the cycle the count equals HOLD_ERRO-1, so ERRO lasts exactly HOLD_ERRO cycles.
  - A new jogada_invalida in ERRO restarts the count at 0.
- VITORIA: displays "J" + digit(vencedor+1). Holds until iniciar -> VEZ; vitoria/empate/jogada_invalida are ignored.
- EMPATE: displays "E" + blank. Holds until iniciar -> VEZ.
- Counter widths: $clog2 of their parameter. Counters never wrap within a state; each is cleared on every state entry.

Optional Feature:
- Macro: CONTROLE_DISPLAY_PISCA_EN.
- Defined:
  - In ERRO and VITORIA, a blink counter toggles the phase every PISCA_PERIODO cycles.
  - Phase 0 (visible) on entry; phase 1 forces both displays to blank.
  - Entering the state again restarts the phase at visible.
- Undefined: no blink logic is synthesised; the messages are steady.

Decomposition:
- Package pkg_display_jogo holds:
  - the segment constants (J, E, 1, 2, dash, blank);
  - the state enum encoding;
  - a function mapping player bit -> digit code.
- One natural sub-module: gerador_pisca. It contains the blink counter and phase flop, with clear on state entry and an enable. It is instantiated only under CONTROLE_DISPLAY_PISCA_EN.

Test Plan:
- Reset mid-ERRO:
  - asserting reset while in ERRO -> immediately db_estado=0, hex_letra=0111111, hex_numero=0111111, ocupado=0.
  - after release, iniciar with jogador=0 -> next cycle db_estado=1, letra=1100001, numero=1111001.
- In VEZ, jogador 0->1 -> hex_numero=0100100 one cycle later.
- Error hold timing:
  - jogada_invalida -> letra=0000110, ocupado=1 for exactly 100 cycles, then back to VEZ.
  - a second jogada_invalida at cycle 50 extends ERRO to 150 cycles total.
- Simultaneous events in VEZ with jogador=1:
  - vitoria and jogada_invalida in the same cycle -> VITORIA, display "J2".
  - jogador later toggling does not change the display.
  - iniciar -> VEZ.
- Empate, then jogada_invalida -> stays in EMPATE, letra=0000110, numero=1111111. iniciar together with vitoria in VEZ -> VEZ wins.
- With CONTROLE_DISPLAY_PISCA_EN: in VITORIA, displays alternate visible/blank every 25 cycles, starting visible. Without the macro: steady.
